nanorv32_muldiv_seq: RTL
========================

// Module: nanorv32_muldiv_seq
// PURPOSE
//  Parametrised iterative RV32M multiply/divide unit for the NANORV32 execute stage.
//  - Replaces the combinational multiplier and fixed divider with one shared datapath.
//  - Retires UNROLL bits per cycle. Uses a valid/ready request/response handshake, a result tag and a flush.
//  - Implements RISC-V divide-by-zero and overflow semantics.
// PARAMETERS
//  DATA_W  32  operand/result width; >=8, multiple of UNROLL
//  UNROLL  1   bits retired per CALC cycle; legal values 1, 2, 4
//  TAG_W   5   width of opaque tag (destination register index)
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  flush        in   1       abort any in-flight operation
//  req_valid    in   1       request present
//  req_ready    out  1       unit can accept a request
//  req_op       in   3       000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  req_a        in   DATA_W  rs1 operand (multiplicand / dividend)
//  req_b        in   DATA_W  rs2 operand (multiplier / divisor)
//  req_tag      in   TAG_W   tag returned with the result
//  resp_valid   out  1       result available
//  resp_ready   in   1       consumer takes the result
//  resp_result  out  DATA_W  result
//  resp_tag     out  TAG_W   tag of the accepted request
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, resp_valid=0, resp_result=0, resp_tag=0, busy=0. All internal registers are cleared.
//  FSM states: IDLE, CALC, FIX, DONE. Define N = DATA_W/UNROLL.
//  Accept: occurs on an edge where req_valid & req_ready & !flush. req_ready = (state==IDLE).
//  On accept edge E0, latch:
//   - op and tag.
//   - absolute values of the operands. Signedness: MULH both operands signed; MULHSU a signed, b unsigned; DIV/REM both signed; all others unsigned.
//   - neg_res:
//     - mul: (sa & a[MSB]) ^ (sb & b[MSB]).
//     - DIV: signs differ.
//     - REM: dividend sign.
//  Special cases are resolved at E0 and go directly IDLE->DONE, so resp_valid is high after E0 (1-edge latency):
//   - div/rem with b==0: DIV/DIVU -> all ones; REM/REMU -> a.
//   - DIV/REM with a==MIN_SIGNED and b==-1: DIV -> MIN_SIGNED; REM -> 0.
//  Otherwise IDLE->CALC.
//  CALC performs one UNROLL-bit step per edge; after N steps, CALC->FIX.
//   - Multiply: shift-add into a 2*DATA_W accumulator.
//   - Divide: restoring; quotient and remainder in DATA_W registers.
//  FIX: conditionally negate (two's complement) per neg_res, select the output, then ->DONE.
//   - Output select: MUL takes product[DATA_W-1:0]; MULH/MULHSU/MULHU take product[2*DATA_W-1:DATA_W]; DIV* take quotient; REM* take remainder.
//  Normal latency: resp_valid rises after edge E0+N+1 (DATA_W=32: UNROLL=1 -> 33 edges, UNROLL=4 -> 9 edges).
//  DONE:
//   - resp_valid=1; resp_result and resp_tag are held stable until resp_ready.
//   - The edge with resp_valid & resp_ready returns to IDLE; req_ready=1 on the following cycle.
//   - There is no same-cycle response/accept overlap.
//  flush:
//   - From any state, the next edge goes to IDLE with resp_valid=0.
//   - flush has priority over accept (a request offered in the flush cycle is dropped) and over resp handshake (the result is discarded).
//  Reset asserted mid-operation: all state returns to reset values immediately; no response is produced.
//  Arithmetic is modulo 2^DATA_W except the 2*DATA_W product. There is no X on resp_result at any time.
// TESTING
//  1. Multiply, a=7, b=0xFFFFFFFD, UNROLL=1:
//     - MUL -> 0xFFFFFFEB.
//     - MULH -> 0xFFFFFFFF.
//     - MULHU -> 0x00000006 (its low word is 0xFFFFFFEB).
//     - MULHSU -> 0x00000006.
//     - resp_valid at edge 33.
//  2. Divide:
//     - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
//     - DIVU 100/7 -> 14; REMU 100/7 -> 2.
//     - resp_tag equals req_tag on every response.
//  3. Corner cases, each with resp_valid after 1 edge:
//     - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
//     - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
//  4. Backpressure: hold resp_ready=0 for 10 cycles in DONE.
//     - resp_valid, resp_result and resp_tag are stable; req_ready=0.
//     - Raise resp_ready -> IDLE on the next edge.
//  5. Flush at CALC step 10:
//     - No response; req_ready=1 after the next edge.
//     - A new MUL 3*4 then returns 12.
//     - Repeat with flush coincident with req_valid -> that request is dropped.
//  6. Reset mid-CALC, then regressions:
//     - Pulse rst_n low mid-CALC -> all outputs at reset values with no response.
//     - Random 10k-op regression for UNROLL=1,2,4 against a reference model.
//     - Check latency N+2 edges (result after edge E0+N+1) for each UNROLL.

Source files
------------

// File: rtl/nanorv32_muldiv_seq.sv
// -----------------------------------------------------------------------------
// nanorv32_muldiv_seq
//   Iterative RV32M multiply/divide unit for the NANORV32 execute stage.
//   A single shared datapath retires UNROLL bits per CALC cycle:
//     - multiply: shift-add into a 2*DATA_W accumulator
//     - divide:   restoring division, remainder in the upper half of the
//                 accumulator and quotient in the lower half
//   Operands are latched as magnitudes and the result sign is fixed up in FIX.
//   Divide-by-zero and signed overflow are resolved at accept and go straight
//   to DONE.
//
// Handshake (both channels): a transfer happens on a rising edge where
//   valid & ready are both high. A request is only taken when flush is low.
//   The response stays valid with result/tag stable until resp_ready is seen.
//   flush wins over both the request and the response transfer.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   flush         abort any in-flight operation, drop any offered request
//   req_valid/req_ready, req_op, req_a, req_b, req_tag   request channel
//   resp_valid/resp_ready, resp_result, resp_tag          response channel
//   busy          high whenever the FSM is not IDLE
//   dbg_state     FSM state (0 IDLE, 1 CALC, 2 FIX, 3 DONE)
// -----------------------------------------------------------------------------
module nanorv32_muldiv_seq #(
  parameter int DATA_W = 32,
  parameter int UNROLL = 1,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int N     = DATA_W / UNROLL;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);
  localparam logic [DATA_W-1:0] MIN_S    = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;   // multiplicand |a| or divisor |b|
  logic [DATA_W-1:0]   res_q, res_d;
  logic [2:0]          op_q, op_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                neg_q, neg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic              accept;
  logic              req_is_div, req_is_rem;
  logic              sa, sb, a_neg, b_neg, neg_in;
  logic [DATA_W-1:0] a_abs, b_abs;
  logic              div_by_zero, div_ovf, special;
  logic [DATA_W-1:0] special_res;

  always_comb begin
    accept      = req_valid & (state_q == S_IDLE) & ~flush;
    req_is_div  = req_op[2];
    req_is_rem  = req_op[2] & req_op[1];
    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed
    sa          = (req_op == 3'b001) | (req_op == 3'b010) |
                  (req_op == 3'b100) | (req_op == 3'b110);
    sb          = (req_op == 3'b001) | (req_op == 3'b100) | (req_op == 3'b110);
    a_neg       = sa & req_a[DATA_W-1];
    b_neg       = sb & req_b[DATA_W-1];
    a_abs       = a_neg ? (DATA_W'(0) - req_a) : req_a;
    b_abs       = b_neg ? (DATA_W'(0) - req_b) : req_b;
    // remainder takes the dividend sign, everything else the product of signs
    neg_in      = req_is_rem ? a_neg : (a_neg ^ b_neg);
    div_by_zero = req_is_div & (req_b == '0);
    div_ovf     = req_is_div & ~req_op[0] & (req_a == MIN_S) & (req_b == '1);
    special     = div_by_zero | div_ovf;
    if (div_by_zero) begin
      special_res = req_op[1] ? req_a : '1;
    end else begin
      special_res = req_op[1] ? '0 : MIN_S;
    end
  end

  // ---------------------------------------------------------------------------
  // Iteration step, UNROLL bits per cycle
  // ---------------------------------------------------------------------------
  logic [2*DATA_W-1:0] m_acc;
  logic [DATA_W:0]     m_sum;
  logic [DATA_W-1:0]   d_rem, d_quo;
  logic [DATA_W:0]     d_sh, d_diff;

  always_comb begin
    m_acc = acc_q;
    m_sum = '0;
    for (int i = 0; i < UNROLL; i++) begin
      // low half holds the not-yet-consumed multiplier bits
      m_sum = {1'b0, m_acc[2*DATA_W-1:DATA_W]} + (m_acc[0] ? {1'b0, opnd_q} : '0);
      m_acc = {m_sum, m_acc[DATA_W-1:1]};
    end
  end

  always_comb begin
    d_rem  = acc_q[2*DATA_W-1:DATA_W];
    d_quo  = acc_q[DATA_W-1:0];
    d_sh   = '0;
    d_diff = '0;
    for (int i = 0; i < UNROLL; i++) begin
      // dividend bits shift out of the quotient register into the remainder
      d_sh   = {d_rem, d_quo[DATA_W-1]};
      d_diff = d_sh - {1'b0, opnd_q};
      if (!d_diff[DATA_W]) begin
        d_rem = d_diff[DATA_W-1:0];
        d_quo = {d_quo[DATA_W-2:0], 1'b1};
      end else begin
        d_rem = d_sh[DATA_W-1:0];
        d_quo = {d_quo[DATA_W-2:0], 1'b0};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sign fix-up and output select
  // ---------------------------------------------------------------------------
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   div_sel, div_fix, fix_res;

  always_comb begin
    // the full product is negated so that the high word sees the borrow
    prod_fix = neg_q ? ((2*DATA_W)'(0) - acc_q) : acc_q;
    div_sel  = op_q[1] ? acc_q[2*DATA_W-1:DATA_W] : acc_q[DATA_W-1:0];
    div_fix  = neg_q ? (DATA_W'(0) - div_sel) : div_sel;
    if (op_q[2]) begin
      fix_res = div_fix;
    end else if (op_q[1:0] == 2'b00) begin
      fix_res = prod_fix[DATA_W-1:0];
    end else begin
      fix_res = prod_fix[2*DATA_W-1:DATA_W];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) state_d = special ? S_DONE : S_CALC;
        S_CALC: if (cnt_q == CNT_LAST) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: if (resp_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    req_ready   = (state_q == S_IDLE);
    resp_valid  = (state_q == S_DONE);
    busy        = (state_q != S_IDLE);
    resp_result = res_q;
    resp_tag    = tag_q;
    dbg_state   = state_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    res_d  = res_q;
    op_d   = op_q;
    tag_d  = tag_q;
    neg_d  = neg_q;
    cnt_d  = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = req_op;
          tag_d = req_tag;
          neg_d = neg_in;
          cnt_d = '0;
          if (special) begin
            res_d = special_res;
          end else if (req_is_div) begin
            acc_d  = {{DATA_W{1'b0}}, a_abs};
            opnd_d = b_abs;
          end else begin
            acc_d  = {{DATA_W{1'b0}}, b_abs};
            opnd_d = a_abs;
          end
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? {d_rem, d_quo} : m_acc;
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_FIX: begin
        res_d = fix_res;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      res_q  <= '0;
      op_q   <= '0;
      tag_q  <= '0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      res_q  <= res_d;
      op_q   <= op_d;
      tag_q  <= tag_d;
      neg_q  <= neg_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
